// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: req/ack handshake plus the
// word-aligned address, lane-replicated write data and byte strobes.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // The LSU drives the request side and listens for ack/read data
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ack,
        input  mem_rdata
    );

    // Memory model / interconnect side
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: effective-address generation, width/alignment
// fault detection, one req/ack memory transaction per access with an
// optional ack timeout, and load-result extraction/extension.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base_addr,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault,
    load_store_unit_if.master mem
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Fault codes reported alongside done
    localparam logic [1:0] FLT_OK      = 2'b00;
    localparam logic [1:0] FLT_MISALGN = 2'b01;
    localparam logic [1:0] FLT_ILLEGAL = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT = 2'b11;

    // RV32I width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Timeout fires on the REQ cycle where the counter has already counted
    // ACK_TIMEOUT-1 ack-less cycles, so mem_req is high exactly ACK_TIMEOUT cycles.
    localparam bit              TO_EN     = (ACK_TIMEOUT != 0);
    localparam int              TO_LAST_I = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST  = TO_LAST_I[CNT_W-1:0];

    // Architectural state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             is_store_q, is_store_d;
    logic [1:0]       fault_q, fault_d;
    logic [31:0]      load_data_q, load_data_d;

    // Registered memory-port outputs, held stable for the whole REQ phase
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;

    // Decode of the incoming request (only meaningful in IDLE)
    logic [31:0] eff_addr;
    logic        f3_illegal;
    logic        f3_misaligned;
    logic [1:0]  start_fault;
    logic [3:0]  lane_hit;
    logic [3:0]  store_strb;
    logic [31:0] store_wdata;

    // Load extraction
    logic [7:0]  rd_bytes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic        timeout_hit;

    assign eff_addr = base_addr + offset;

    // Per-lane byte decode: one-hot lane select for SB strobes and the
    // byte slices of the read word for load extraction
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi] = (eff_addr[1:0] == 2'(gi));
            assign rd_bytes[gi] = mem.mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Width legality is decided first; alignment only matters for a legal width
    always_comb begin
        f3_illegal = 1'b0;
        if (is_store) begin
            f3_illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            f3_illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                           funct3 == F3_BU || funct3 == F3_HU);
        end

        case (funct3[1:0])
            2'b01:   f3_misaligned = eff_addr[0];
            2'b10:   f3_misaligned = (eff_addr[1:0] != 2'b00);
            default: f3_misaligned = 1'b0;
        endcase

        if (f3_illegal) begin
            start_fault = FLT_ILLEGAL;
        end else if (f3_misaligned) begin
            start_fault = FLT_MISALGN;
        end else begin
            start_fault = FLT_OK;
        end
    end

    // Store lane replication and byte strobes; loads never write any byte
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                store_wdata = {4{store_data[7:0]}};
                store_strb  = lane_hit;
            end
            2'b01: begin
                store_wdata = {2{store_data[15:0]}};
                store_strb  = eff_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_wdata = store_data;
                store_strb  = 4'b1111;
            end
        endcase
        if (!is_store) begin
            store_strb = 4'b0000;
        end
    end

    // Pick the addressed byte/halfword of the read word and extend it
    always_comb begin
        byte_sel = rd_bytes[addr_lo_q];
        half_sel = addr_lo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (funct3_q)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_ext = mem.mem_rdata;
            F3_BU:   load_ext = {24'h000000, byte_sel};
            F3_HU:   load_ext = {16'h0000, half_sel};
            default: load_ext = 32'h0000_0000;
        endcase
    end

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    // Next-state logic for the IDLE -> REQ -> DONE sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        fault_d     = fault_q;
        load_data_d = load_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_lo_d  = eff_addr[1:0];
                    funct3_d   = funct3;
                    is_store_d = is_store;
                    if (start_fault != FLT_OK) begin
                        // Faulted accesses never reach the memory port
                        state_d     = ST_DONE;
                        fault_d     = start_fault;
                        load_data_d = 32'h0000_0000;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {eff_addr[31:2], 2'b00};
                        mem_wdata_d = store_wdata;
                        mem_wstrb_d = store_strb;
                    end
                end
            end

            ST_REQ: begin
                // Ack takes priority over a timeout expiring on the same cycle
                if (mem.mem_ack) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    fault_d     = FLT_OK;
                    load_data_d = is_store_q ? 32'h0000_0000 : load_ext;
                end else if (timeout_hit) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    fault_d     = FLT_TIMEOUT;
                    load_data_d = 32'h0000_0000;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any in-flight access without a done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_lo_q   <= 2'b00;
            funct3_q    <= 3'b000;
            is_store_q  <= 1'b0;
            fault_q     <= FLT_OK;
            load_data_q <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign fault         = fault_q;
    assign load_data     = load_data_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scenario tasks drive accesses and
// check memory-port timing inline; a done monitor pops the expected
// load_data/fault pair from a scoreboard queue on every done pulse.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base_addr;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  fault;

    load_store_unit_if bus ();

    load_store_unit #(
        .ACK_TIMEOUT (4),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .base_addr  (base_addr),
        .offset     (offset),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .fault      (fault),
        .mem        (bus.master)
    );

    typedef struct packed {
        logic [31:0] ld;
        logic [1:0]  flt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got done with load_data=%h fault=%b, want no done",
                         load_data, fault);
            end else begin
                e = sb.pop_front();
                if (load_data !== e.ld) begin
                    n_fail++;
                    $display("FAIL sb_load_data: got %h want %h", load_data, e.ld);
                end
                n_checks++;
                if (fault !== e.flt) begin
                    n_fail++;
                    $display("FAIL sb_fault: got %b want %b", fault, e.flt);
                end
                $display("txn done: load_data=%h fault=%b", load_data, fault);
            end
        end
    end

    // Present one start request for a single edge; returns #1 after that edge
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd);
        start      = 1'b1;
        is_store   = st;
        funct3     = f3;
        base_addr  = b;
        offset     = o;
        store_data = sd;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, bus.mem_req, bus.mem_we, bus.mem_wstrb, fault} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b done=%b req=%b we=%b wstrb=%b fault=%b, want all 0",
                     busy, done, bus.mem_req, bus.mem_we, bus.mem_wstrb, fault);
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, load_data} !== 96'b0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h load_data=%h, want 0",
                     bus.mem_addr, bus.mem_wdata, load_data);
        end
        rst = 1'b0;
        // A stray ack while idle must not start or finish anything
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if ({busy, done, bus.mem_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got busy=%b done=%b req=%b want 000", busy, done, bus.mem_req);
        end
    endtask

    task automatic test_lb();
        sb.push_back('{ld: 32'hFFFFFF80, flt: 2'b00});
        issue(1'b0, 3'b000, 32'h0000_1000, 32'd3, 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h80AABBCC;
        @(negedge clk);
        n_checks++;
        if (bus.mem_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_req: got req=%b busy=%b done=%b want 1 1 0", bus.mem_req, busy, done);
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0000_1000 || bus.mem_wstrb !== 4'b0000 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_port: got addr=%h wstrb=%b we=%b want 00001000 0000 0",
                     bus.mem_addr, bus.mem_wstrb, bus.mem_we);
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_done_latency: got done=%b req=%b want 1 0", done, bus.mem_req);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_back_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_lhu();
        sb.push_back('{ld: 32'h00008001, flt: 2'b00});
        issue(1'b0, 3'b101, 32'h0000_1004, 32'hFFFF_FFFE, 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h80011234;
        @(negedge clk);
        n_checks++;
        if (bus.mem_addr !== 32'h0000_1000 || bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL lhu_addr: got addr=%h req=%b want 00001000 1", bus.mem_addr, bus.mem_req);
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL lhu_done: got done=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_sb_wait();
        int bad = 0;
        sb.push_back('{ld: 32'h0, flt: 2'b00});
        issue(1'b1, 3'b000, 32'h0000_2000, 32'd1, 32'h12345678);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0000_2000 ||
                bus.mem_wdata !== 32'h78787878 || bus.mem_wstrb !== 4'b0010 || done !== 1'b0) begin
                bad++;
                $display("FAIL sb_stable cycle %0d: got req=%b we=%b addr=%h wdata=%h wstrb=%b done=%b want 1 1 00002000 78787878 0010 0",
                         k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, done);
            end
            if (k == 3) bus.mem_ack = 1'b1;
        end
        n_checks++;
        if (bad != 0) n_fail++;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_done_after_ack: got done=%b req=%b want 1 0", done, bus.mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_faults();
        // LW at 0x1002: misaligned, no memory request, done right after start
        sb.push_back('{ld: 32'h0, flt: 2'b01});
        issue(1'b0, 3'b010, 32'h0000_1000, 32'd2, 32'h0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || bus.mem_req !== 1'b0 || fault !== 2'b01) begin
            n_fail++;
            $display("FAIL lw_misaligned: got done=%b req=%b fault=%b want 1 0 01", done, bus.mem_req, fault);
        end
        @(negedge clk);
        // Load funct3 = 111 is illegal
        sb.push_back('{ld: 32'h0, flt: 2'b10});
        issue(1'b0, 3'b111, 32'h0000_1000, 32'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || bus.mem_req !== 1'b0 || fault !== 2'b10) begin
            n_fail++;
            $display("FAIL ld_illegal: got done=%b req=%b fault=%b want 1 0 10", done, bus.mem_req, fault);
        end
        @(negedge clk);
        // Store funct3 = 100 is illegal, and wins over misalignment
        sb.push_back('{ld: 32'h0, flt: 2'b10});
        issue(1'b1, 3'b100, 32'h0000_1001, 32'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || bus.mem_req !== 1'b0 || fault !== 2'b10) begin
            n_fail++;
            $display("FAIL st_illegal: got done=%b req=%b fault=%b want 1 0 10", done, bus.mem_req, fault);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int d0;
        d0 = done_cnt;
        sb.push_back('{ld: 32'hDEADBEEF, flt: 2'b00});
        issue(1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'h0);
        // Hold a would-fault start high through REQ and DONE
        start  = 1'b1;
        funct3 = 3'b111;
        @(negedge clk);
        n_checks++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_req: got req=%b want 1", bus.mem_req);
        end
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_done: got done=%b want 1", done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got busy=%b done=%b want 0 0", busy, done);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL busy_done_count: got %0d done pulses want 1", done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int  req_cycles = 0;
        bit  seen = 0;
        sb.push_back('{ld: 32'h0, flt: 2'b11});
        issue(1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'h0);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (bus.mem_req) req_cycles++;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout_done: got no done within 20 cycles want done");
        end
        n_checks++;
        if (req_cycles != 4 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got %0d cycles (req now %b) want 4 (req now 0)",
                     req_cycles, bus.mem_req);
        end
        @(negedge clk);
        // Ack arriving on the expiry cycle takes priority
        sb.push_back('{ld: 32'hFFFFF00D, flt: 2'b00});
        issue(1'b0, 3'b001, 32'h0000_1000, 32'd0, 32'h0);
        bus.mem_rdata = 32'h0000F00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) bus.mem_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || fault !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_ack_wins: got done=%b fault=%b want 1 00", done, fault);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int d0;
        issue(1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_req: got req=%b want 1", bus.mem_req);
        end
        d0  = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_abort: got req=%b busy=%b done=%b want 0 0 0", bus.mem_req, busy, done);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: got %0d done pulses want 0", done_cnt - d0);
        end
        // Follow-up SW completes normally
        sb.push_back('{ld: 32'h0, flt: 2'b00});
        issue(1'b1, 3'b010, 32'h0000_3000, 32'd0, 32'hCAFEF00D);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.mem_wstrb !== 4'b1111 || bus.mem_wdata !== 32'hCAFEF00D ||
            bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL sw_port: got wstrb=%b wdata=%h we=%b addr=%h want 1111 cafef00d 1 00003000",
                     bus.mem_wstrb, bus.mem_wdata, bus.mem_we, bus.mem_addr);
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_done: got done=%b want 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        is_store      = 1'b0;
        funct3        = 3'b000;
        base_addr     = 32'h0;
        offset        = 32'h0;
        store_data    = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        test_reset();
        test_lb();
        test_lhu();
        test_sb_wait();
        test_faults();
        test_busy_ignore();
        test_timeout();
        test_rst_mid();

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d results never produced want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
